mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 100 ++++++++++
 tb/tb_mem_responder.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Wait-stated single-port word memory with a four-phase request/acknowledge handshake.
// Requests are latched on acceptance; illegal requests are acknowledged with MemErr instead.
module mem_responder #(
  parameter int unsigned ADDR_BITS   = 9,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] Address,
  input  logic        Read,
  input  logic        Write,
  input  logic [31:0] DataIn,
  output logic [31:0] Mdatain,
  output logic        MemDone,
  output logic        Busy,
  output logic        MemErr
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE, ERR} state_e;

  state_e                 state_q;
  logic [3:0]             cnt_q;
  logic [ADDR_BITS-1:0]   addr_q;
  logic [31:0]            data_q;
  logic                   we_q;
  logic [31:0]            mdata_q;
  logic                   done_q;
  logic                   busy_q;
  logic                   err_q;

  logic [31:0] mem [2**ADDR_BITS];

  logic bad_addr;
  logic commit;

  assign bad_addr = (Address >> ADDR_BITS) != 32'd0;
  assign commit   = (state_q == ACCESS) && (cnt_q == 4'd0);

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      mdata_q <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (Read && Write || (Read ^ Write) && bad_addr) begin
            state_q <= ERR;
            done_q  <= 1'b1;
            busy_q  <= 1'b1;
            err_q   <= 1'b1;
          end else if (Read ^ Write) begin
            state_q <= ACCESS;
            cnt_q   <= 4'(WAIT_STATES);
            addr_q  <= Address[ADDR_BITS-1:0];
            data_q  <= DataIn;
            we_q    <= Write;
            busy_q  <= 1'b1;
          end
        end
        ACCESS: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            state_q <= DONE;
            done_q  <= 1'b1;
            if (!we_q) mdata_q <= mem[addr_q];
          end
        end
        DONE, ERR: begin
          // Leave only once the requester has dropped both strobes.
          if (!Read && !Write) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // No reset on the array: contents survive clear, and clear forces IDLE so commit drops.
  always_ff @(posedge clock) begin
    if (commit && we_q) mem[addr_q] <= data_q;
  end

  assign Mdatain = mdata_q;
  assign MemDone = done_q;
  assign Busy    = busy_q;
  assign MemErr  = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed plus randomized checks of mem_responder against a word-array reference model.
module tb_mem_responder;

  localparam int unsigned AB = 9;
  localparam int unsigned WS = 2;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] Address = '0;
  logic        Read = 1'b0;
  logic        Write = 1'b0;
  logic [31:0] DataIn = '0;
  logic [31:0] Mdatain;
  logic        MemDone, Busy, MemErr;

  int checks = 0;
  int errors = 0;

  logic [31:0] model_mem [int];
  logic [31:0] exp_md = '0;
  int unsigned written [$];

  mem_responder #(.ADDR_BITS(AB), .WAIT_STATES(WS)) dut (
    .clock(clock), .clear(clear), .Address(Address), .Read(Read), .Write(Write),
    .DataIn(DataIn), .Mdatain(Mdatain), .MemDone(MemDone), .Busy(Busy), .MemErr(MemErr)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Issues one request, optionally churns inputs during ACCESS and holds the request after done.
  task automatic req(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                     input bit churn, input int hold);
    bit err;
    int n;
    int lat;
    err = (rd && wr) || (a >= (32'd1 << AB));
    lat = err ? 1 : WS + 2;
    @(negedge clock);
    Read = rd; Write = wr; Address = a; DataIn = d;
    n = 0;
    while (!MemDone && n < 40) begin
      @(posedge clock); #1;
      n++;
      if (churn && n == 1) begin
        Address = $urandom; DataIn = $urandom;
      end
    end
    check("latency", 32'(n), 32'(lat));
    if (!err) begin
      if (wr) begin
        model_mem[int'(a)] = d;
        written.push_back(a);
      end else begin
        exp_md = model_mem[int'(a)];
      end
    end
    check("memerr", {31'd0, MemErr}, {31'd0, err});
    check("busy_done", {31'd0, Busy}, 32'd1);
    check("mdatain", Mdatain, exp_md);
    for (int i = 0; i < hold; i++) begin
      @(posedge clock); #1;
      check("hold_done", {30'd0, MemDone, Busy}, 32'd3);
    end
    @(negedge clock);
    Read = 1'b0; Write = 1'b0;
    @(posedge clock); #1;
    check("release", {29'd0, MemDone, Busy, MemErr}, 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    #12;
    check("reset_outs", {29'd0, MemDone, Busy, MemErr}, 32'd0);
    check("reset_md", Mdatain, 32'd0);
    clear = 1'b1;

    req(1'b0, 1'b1, 32'd5, 32'hDEADBEEF, 1'b0, 0);
    req(1'b1, 1'b0, 32'd5, 32'd0, 1'b0, 0);

    // Both strobes: error, word 5 untouched
    req(1'b1, 1'b1, 32'd5, 32'h12345678, 1'b0, 0);
    req(1'b1, 1'b0, 32'd5, 32'd0, 1'b0, 0);

    // Out-of-range address aliases word 0 if the range check were missing
    req(1'b0, 1'b1, 32'd0, 32'hA5A5A5A5, 1'b0, 0);
    req(1'b0, 1'b1, 32'h00000200, 32'h11112222, 1'b0, 0);
    req(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 0);

    req(1'b1, 1'b0, 32'd5, 32'd0, 1'b0, 10);

    req(1'b0, 1'b1, 32'd511, 32'hCAFEF00D, 1'b1, 0);
    req(1'b1, 1'b0, 32'd511, 32'd0, 1'b1, 0);

    // Reset one cycle into ACCESS of a write to word 5
    @(negedge clock);
    Write = 1'b1; Address = 32'd5; DataIn = 32'h0BADF00D;
    @(posedge clock); #1;
    check("in_access_busy", {30'd0, Busy, MemDone}, 32'd2);
    @(posedge clock); #1;
    clear = 1'b0;
    #1;
    check("midreset_outs", {29'd0, MemDone, Busy, MemErr}, 32'd0);
    check("midreset_md", Mdatain, 32'd0);
    exp_md = '0;
    Write = 1'b0;
    @(negedge clock);
    clear = 1'b1;
    req(1'b1, 1'b0, 32'd5, 32'd0, 1'b0, 0);

    for (int k = 0; k < 30; k++) begin
      int unsigned sel;
      sel = $urandom_range(0, 9);
      d = $urandom;
      if (sel < 4 || written.size() == 0) begin
        a = 32'($urandom_range(0, 511));
        req(1'b0, 1'b1, a, d, sel[0], 0);
      end else if (sel < 8) begin
        a = written[$urandom_range(0, written.size() - 1)];
        req(1'b1, 1'b0, a, d, sel[0], 0);
      end else if (sel == 8) begin
        a = 32'($urandom_range(512, 32'hFFFF));
        req(1'b0, 1'b1, a, d, 1'b0, 0);
      end else begin
        a = written[$urandom_range(0, written.size() - 1)];
        req(1'b1, 1'b1, a, d, 1'b0, 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
